// File: rtl/plic_gateway_pkg.sv
// Shared types and constants for the PLIC interrupt gateway.
// Register offsets, data width and the per-source gateway state encoding.
package plic_gateway_pkg;

  localparam int XLEN = 32;
  localparam int ID_W = 5;

  localparam logic [3:0] REG_MODE     = 4'h0;
  localparam logic [3:0] REG_POLARITY = 4'h4;
  localparam logic [3:0] REG_INFLIGHT = 4'h8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    REARM  = 2'd2
  } gw_state_e;

endpackage

// File: rtl/plic_gateway_if.sv
// Register access bus of the gateway (PBUS style strobe, byte-enabled writes,
// combinational read data). Signal names are from the gateway's point of view.
interface plic_gateway_if;

  logic                                stb_i;
  logic [3:0]                          adr_i;
  logic [3:0]                          byte_sel_i;
  logic                                we_i;
  logic [plic_gateway_pkg::XLEN-1:0]   dat_i;
  logic [plic_gateway_pkg::XLEN-1:0]   dat_o;

  modport master (output stb_i, adr_i, byte_sel_i, we_i, dat_i, input dat_o);
  modport slave  (input stb_i, adr_i, byte_sel_i, we_i, dat_i, output dat_o);

endinterface

// File: rtl/plic_gateway_cell.sv
// One interrupt source: edge detector, single-deep edge memory, and the
// IDLE/ASSERT/REARM sequencer that holds the request until its completion.
module plic_gateway_cell
  import plic_gateway_pkg::*;
#(
  parameter int unsigned ID             = 1,
  parameter int unsigned MIN_LOW_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            act_i,
  input  logic            prev_load_i,
  input  logic            prev_val_i,
  input  logic            mode_i,
  input  logic            complete_valid_i,
  input  logic [ID_W-1:0] complete_id_i,
  output logic            irq_o
);

  localparam int CNT_W = (MIN_LOW_CYCLES > 1) ? $clog2(MIN_LOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MIN_LOW_CYCLES - 1);
  localparam logic [ID_W-1:0]  MY_ID    = ID_W'(ID);

  gw_state_e        state_q, state_d;
  logic             edge_pend_q, edge_pend_d;
  logic             act_prev_q, act_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             edge_seen;

  assign edge_seen = act_i & ~act_prev_q;
  assign irq_o     = (state_q == ASSERT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      edge_pend_q <= 1'b0;
      act_prev_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      edge_pend_q <= edge_pend_d;
      act_prev_q  <= act_prev_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    edge_pend_d = edge_pend_q;
    cnt_d       = cnt_q;
    // A polarity change re-seeds the previous value so the flip is not an edge.
    act_prev_d  = prev_load_i ? prev_val_i : act_i;
    unique case (state_q)
      IDLE: begin
        if (mode_i ? (edge_seen | edge_pend_q) : act_i) begin
          state_d     = ASSERT;
          edge_pend_d = 1'b0;
        end
      end
      ASSERT: begin
        if (edge_seen) edge_pend_d = 1'b1;
        if (complete_valid_i && (complete_id_i == MY_ID)) begin
          state_d = REARM;
          cnt_d   = CNT_LOAD;
        end
      end
      REARM: begin
        if (edge_seen) edge_pend_d = 1'b1;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/plic_gateway.sv
// Interrupt gateway in front of the PLIC: input synchronisers, MODE/POLARITY
// register file, and one gateway cell per source (source 0 is reserved).
module plic_gateway
  import plic_gateway_pkg::*;
#(
  parameter int unsigned NUM_SOURCES    = 32,
  parameter int unsigned MIN_LOW_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  plic_gateway_if.slave          bus,
  input  logic [NUM_SOURCES-1:0] irq_raw_i,
  input  logic                   complete_valid_i,
  input  logic [ID_W-1:0]        complete_id_i,
  output logic [NUM_SOURCES-1:0] irq_o
);

  logic [NUM_SOURCES-1:1] sync1_q, sync2_q;
  logic [NUM_SOURCES-1:1] mode_q, mode_d;
  logic [NUM_SOURCES-1:1] pol_q, pol_d;
  logic [NUM_SOURCES-1:1] wr_mask, wdat;
  logic [NUM_SOURCES-1:1] act, act_next, irq_src;
  logic [XLEN-1:0]        bit_en;
  logic [XLEN-1:0]        rdata;
  logic                   mode_wr, pol_wr;
  logic                   unused_lo;

  genvar gi;

  for (gi = 0; gi < XLEN; gi++) begin : g_bit_en
    assign bit_en[gi] = bus.byte_sel_i[gi/8];
  end

  assign wr_mask  = bit_en[NUM_SOURCES-1:1];
  assign wdat     = bus.dat_i[NUM_SOURCES-1:1];
  assign mode_wr  = bus.stb_i & bus.we_i & (bus.adr_i == REG_MODE);
  assign pol_wr   = bus.stb_i & bus.we_i & (bus.adr_i == REG_POLARITY);
  assign mode_d   = mode_wr ? ((mode_q & ~wr_mask) | (wdat & wr_mask)) : mode_q;
  assign pol_d    = pol_wr  ? ((pol_q  & ~wr_mask) | (wdat & wr_mask)) : pol_q;
  assign act      = sync2_q ^ pol_q;
  // Value act will take next cycle, used to re-seed the edge detector on a polarity write.
  assign act_next = sync1_q ^ pol_d;

  assign unused_lo = ^{irq_raw_i[0], bus.dat_i[0], bit_en[0]};
  if (NUM_SOURCES < XLEN) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^{bus.dat_i[XLEN-1:NUM_SOURCES], bit_en[XLEN-1:NUM_SOURCES]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      mode_q  <= '0;
      pol_q   <= '0;
    end else begin
      sync1_q <= irq_raw_i[NUM_SOURCES-1:1];
      sync2_q <= sync1_q;
      mode_q  <= mode_d;
      pol_q   <= pol_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.stb_i) begin
      unique case (bus.adr_i)
        REG_MODE:     rdata[NUM_SOURCES-1:0] = {mode_q, 1'b0};
        REG_POLARITY: rdata[NUM_SOURCES-1:0] = {pol_q, 1'b0};
        REG_INFLIGHT: rdata[NUM_SOURCES-1:0] = {irq_src, 1'b0};
        default:      rdata = '0;
      endcase
    end
  end
  assign bus.dat_o = rdata;

  for (gi = 1; gi < NUM_SOURCES; gi++) begin : g_cell
    plic_gateway_cell #(
      .ID             (gi),
      .MIN_LOW_CYCLES (MIN_LOW_CYCLES)
    ) u_cell (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .act_i            (act[gi]),
      .prev_load_i      (pol_wr & wr_mask[gi]),
      .prev_val_i       (act_next[gi]),
      .mode_i           (mode_q[gi]),
      .complete_valid_i (complete_valid_i),
      .complete_id_i    (complete_id_i),
      .irq_o            (irq_src[gi])
    );
  end

  assign irq_o = {irq_src, 1'b0};

endmodule
